// File: rtl/cordic_pkg.sv
// Shared definitions for the hyperbolic CORDIC engine.
//   mode_t      : ROTATE drives z to zero, VECTOR drives y to zero.
//   state_t     : engine control states (IDLE, RUN, DONE).
//   atanh_lut() : atanh(2^-k) rounded to ATANH_FRAC fractional bits, k = 1..40.
//   is_repeat() : true for the shift indices that hyperbolic CORDIC runs twice.
//   iter_count(): total micro-rotations for a given number of distinct shifts.
package cordic_pkg;

    typedef enum logic {
        ROTATE = 1'b0,
        VECTOR = 1'b1
    } mode_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Width of the shift-index register; covers k = 0..63.
    localparam int KW = 6;

    // Fractional precision the angle table is written in.
    localparam int ATANH_FRAC = 12;

    // Indices that must be executed twice for hyperbolic convergence.
    localparam int REP_A = 4;
    localparam int REP_B = 13;
    localparam int REP_C = 40;

    // atanh(2^-k) * 2^12, rounded to nearest. From k = 14 upward the value
    // is below half an LSB and rounds to zero. k = 13 sits just above 0.5
    // LSB (atanh(t) > t) and therefore rounds up to 1.
    function automatic logic [15:0] atanh_lut(input logic [KW-1:0] k);
        case (k)
            6'd1:    return 16'd2250;
            6'd2:    return 16'd1046;
            6'd3:    return 16'd515;
            6'd4:    return 16'd256;
            6'd5:    return 16'd128;
            6'd6:    return 16'd64;
            6'd7:    return 16'd32;
            6'd8:    return 16'd16;
            6'd9:    return 16'd8;
            6'd10:   return 16'd4;
            6'd11:   return 16'd2;
            6'd12:   return 16'd1;
            6'd13:   return 16'd1;
            default: return 16'd0;
        endcase
    endfunction

    function automatic logic is_repeat(input logic [KW-1:0] k);
        return (k == KW'(REP_A)) || (k == KW'(REP_B)) || (k == KW'(REP_C));
    endfunction

    function automatic int iter_count(input int niter);
        int n;
        n = niter;
        if (niter >= REP_A) n = n + 1;
        if (niter >= REP_B) n = n + 1;
        if (niter >= REP_C) n = n + 1;
        return n;
    endfunction

endpackage

// File: rtl/cordic_hyp_stage.sv
// Combinational single hyperbolic CORDIC micro-rotation.
//   x, y, z            : current state, two's complement, W bits
//   k                  : shift index for this iteration
//   mode               : ROTATE steers on sign of z, VECTOR on sign of y
//   x_next/y_next/z_next : rotated state
// The direction d is +1 when z >= 0 (rotate) or y < 0 (vector), else -1.
module cordic_hyp_stage
    import cordic_pkg::*;
#(
    parameter int W    = 18,
    parameter int FRAC = 12
) (
    input  logic signed [W-1:0]  x,
    input  logic signed [W-1:0]  y,
    input  logic signed [W-1:0]  z,
    input  logic        [KW-1:0] k,
    input  mode_t                mode,
    output logic signed [W-1:0]  x_next,
    output logic signed [W-1:0]  y_next,
    output logic signed [W-1:0]  z_next
);

    logic               d_pos;
    logic signed [W-1:0] x_sh;
    logic signed [W-1:0] y_sh;
    logic        [W-1:0] lut_w;
    logic signed [W-1:0] ang;

    assign d_pos = (mode == ROTATE) ? !z[W-1] : y[W-1];

    assign x_sh = x >>> k;
    assign y_sh = y >>> k;

    // Rescale the table from its native 12 fractional bits to FRAC.
    assign lut_w = W'(atanh_lut(k));
    assign ang   = (FRAC >= ATANH_FRAC) ? $signed(lut_w << (FRAC - ATANH_FRAC))
                                        : $signed(lut_w >> (ATANH_FRAC - FRAC));

    always_comb begin
        x_next = x;
        y_next = y;
        z_next = z;
        if (d_pos) begin
            x_next = x + y_sh;
            y_next = y + x_sh;
            z_next = z - ang;
        end else begin
            x_next = x - y_sh;
            y_next = y - x_sh;
            z_next = z + ang;
        end
    end

endmodule

// File: rtl/hyperbolic_cordic_engine.sv
// Iterative hyperbolic CORDIC engine, one micro-rotation per clock.
//   clk, rst          : clock, synchronous active-high reset
//   iValid/oReady     : operand handshake (iX, iY, iZ, iMode, iBypass)
//   oValid/iReady     : result handshake (oX, oY, oZ, oSat)
//   dbg_state         : current control state for observation
//
// Handshake: a transfer happens on a rising edge where valid && ready are
// both high. oReady is high only in IDLE. Once oValid is high, oX/oY/oZ/oSat
// and oValid hold until the edge where iReady is high; oValid drops after it.
//
// Timing: the accept edge loads x/y/z; RUN performs ITER iterations, one per
// edge; the first edge in DONE clamps and registers the result and raises
// oValid. That gives ITER + 1 cycles from accept to oValid, and 1 cycle for
// bypass, which goes straight from IDLE to DONE.
module hyperbolic_cordic_engine
    import cordic_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int FRAC   = 12,
    parameter int NITER  = 12,
    parameter int GUARD  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              iValid,
    output logic              oReady,
    input  logic              iMode,
    input  logic              iBypass,
    input  logic [DWIDTH-1:0] iX,
    input  logic [DWIDTH-1:0] iY,
    input  logic [DWIDTH-1:0] iZ,
    output logic              oValid,
    input  logic              iReady,
    output logic [DWIDTH-1:0] oX,
    output logic [DWIDTH-1:0] oY,
    output logic [DWIDTH-1:0] oZ,
    output logic              oSat,
    output state_t            dbg_state
);

    localparam int W    = DWIDTH + GUARD;
    localparam int ITER = iter_count(NITER);
    localparam int CW   = $clog2(ITER + 1);

    localparam logic signed [W-1:0] SAT_MAX = W'((2 ** (DWIDTH - 1)) - 1);
    localparam logic signed [W-1:0] SAT_MIN = ~SAT_MAX;

    state_t              state;
    state_t              state_next;
    mode_t               mode_q;
    logic signed [W-1:0] x_q, y_q, z_q;
    logic signed [W-1:0] x_n, y_n, z_n;
    logic [KW-1:0]       k_q;
    logic                rep_q;     // second pass of a repeated index done
    logic [CW-1:0]       iter_q;
    logic                accept;
    logic                last_iter;
    logic [DWIDTH:0]     cx, cy, cz;

    // Returns {clipped, value} for one internal value.
    function automatic logic [DWIDTH:0] clamp(input logic signed [W-1:0] v);
        if (v > SAT_MAX)
            return {1'b1, SAT_MAX[DWIDTH-1:0]};
        else if (v < SAT_MIN)
            return {1'b1, SAT_MIN[DWIDTH-1:0]};
        else
            return {1'b0, v[DWIDTH-1:0]};
    endfunction

    assign oReady    = (state == IDLE);
    assign accept    = iValid && oReady;
    assign last_iter = (iter_q == CW'(ITER - 1));
    assign dbg_state = state;

    cordic_hyp_stage #(
        .W    (W),
        .FRAC (FRAC)
    ) u_stage (
        .x      (x_q),
        .y      (y_q),
        .z      (z_q),
        .k      (k_q),
        .mode   (mode_q),
        .x_next (x_n),
        .y_next (y_n),
        .z_next (z_n)
    );

    always_comb begin
        cx = clamp(x_q);
        cy = clamp(y_q);
        cz = clamp(z_q);
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept)            state_next = iBypass ? DONE : RUN;
            RUN:     if (last_iter)         state_next = DONE;
            DONE:    if (oValid && iReady)  state_next = IDLE;
            default:                        state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= '0;
            y_q    <= '0;
            z_q    <= '0;
            mode_q <= ROTATE;
            k_q    <= '0;
            rep_q  <= 1'b0;
            iter_q <= '0;
            oValid <= 1'b0;
            oX     <= '0;
            oY     <= '0;
            oZ     <= '0;
            oSat   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        x_q    <= {{GUARD{iX[DWIDTH-1]}}, iX};
                        y_q    <= {{GUARD{iY[DWIDTH-1]}}, iY};
                        z_q    <= {{GUARD{iZ[DWIDTH-1]}}, iZ};
                        mode_q <= mode_t'(iMode);
                        k_q    <= KW'(1);
                        rep_q  <= 1'b0;
                        iter_q <= '0;
                    end
                end
                RUN: begin
                    x_q    <= x_n;
                    y_q    <= y_n;
                    z_q    <= z_n;
                    iter_q <= iter_q + CW'(1);
                    // Hold k for one extra iteration on repeat indices.
                    if (is_repeat(k_q) && !rep_q) begin
                        rep_q <= 1'b1;
                    end else begin
                        k_q   <= k_q + KW'(1);
                        rep_q <= 1'b0;
                    end
                end
                DONE: begin
                    if (!oValid) begin
                        oX     <= cx[DWIDTH-1:0];
                        oY     <= cy[DWIDTH-1:0];
                        oZ     <= cz[DWIDTH-1:0];
                        oSat   <= cx[DWIDTH] | cy[DWIDTH] | cz[DWIDTH];
                        oValid <= 1'b1;
                    end else if (iReady) begin
                        oValid <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
